muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 42 ++++
 rtl/muldiv_unit.sv | 126 ++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   DATA_W   - operand / result width
//   ITER_CNT - iterations per operation (one bit per cycle)
//   op_e     - operation encoding on op_i
//   state_e  - control FSM states
package muldiv_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Divide-class ops share the restoring-divide datapath.
  function automatic logic is_div_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the multiply/divide datapath.
//   div_mode - 0: shift-add multiply step, 1: restoring-divide step
//   acc      - working register; multiply {product_hi, multiplier_remaining},
//              divide {partial_remainder, dividend/quotient bits}
//   opnd     - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_nxt  - working register after this step
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic                  div_mode,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  always_comb begin
    sum     = '0;
    shifted = '0;
    trial   = '0;
    acc_nxt = acc;
    if (!div_mode) begin
      // Add multiplicand into the high half when the current multiplier bit
      // is set, then shift the whole register right; the carry lands in bit 63.
      sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
      acc_nxt = {sum, acc[DATA_W-1:1]};
    end else begin
      // Bring the next dividend bit into the remainder and trial-subtract.
      // The 33-bit difference stays within +/-2^32, so bit 32 is its sign.
      shifted = acc[2*DATA_W-1:DATA_W-1];
      trial   = shifted - {1'b0, opnd};
      if (!trial[DATA_W])
        acc_nxt = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else
        acc_nxt = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle iterative signed multiply / divide for the EX stage.
//   clk_i, rst_n_i      - clock, asynchronous active-low reset
//   start_i, op_i       - launch request and operation (MUL/MULH/DIV/REM)
//   data1_i, data2_i    - operands A and B, sampled only when accepted
//   flush_i             - abort an in-flight operation
//   stall_o             - hold the front of the pipeline while working
//   done_o, result_o    - one-cycle completion pulse and held result
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  state_e                state;
  op_e                   op_q;
  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;
  logic                  neg_a;
  logic                  neg_b;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   acc_nxt;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Apply operand signs to the unsigned datapath result and select the field.
  function automatic logic [DATA_W-1:0] fix_result(input op_e op,
                                                   input logic [2*DATA_W-1:0] raw,
                                                   input logic sa, input logic sb,
                                                   input logic b_zero);
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          quo;
    logic [DATA_W-1:0]          rem;
    logic [DATA_W-1:0]          res;
    prod = (sa ^ sb) ? -$signed(raw) : $signed(raw);
    quo  = (sa ^ sb) ? -raw[DATA_W-1:0] : raw[DATA_W-1:0];
    // Remainder takes the dividend's sign; a zero divisor leaves |A| here,
    // so REM by zero naturally returns A.
    rem  = sa ? -raw[2*DATA_W-1:DATA_W] : raw[2*DATA_W-1:DATA_W];
    case (op)
      OP_MUL:  res = prod[DATA_W-1:0];
      OP_MULH: res = prod[2*DATA_W-1:DATA_W];
      OP_DIV:  res = b_zero ? {DATA_W{1'b1}} : quo;
      default: res = rem;
    endcase
    return res;
  endfunction

  muldiv_iter u_iter (
    .div_mode (is_div_op(op_q)),
    .acc      (acc),
    .opnd     (is_div_op(op_q) ? mag_b : mag_a),
    .acc_nxt  (acc_nxt)
  );

  // Stall must rise in the accepting cycle itself, so it is decoded from the
  // live request; reset masks it so a held start_i has no effect.
  assign stall_o = rst_n_i &&
                   (((state == ST_IDLE) && start_i && !flush_i) || (state == ST_BUSY));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        // Accept: capture op, magnitudes and signs; seed the working register.
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i && !flush_i) begin
            op_q  <= op_e'(op_i);
            mag_a <= abs_val(data1_i);
            mag_b <= abs_val(data2_i);
            neg_a <= data1_i[DATA_W-1];
            neg_b <= data2_i[DATA_W-1];
            cnt   <= '0;
            acc   <= op_i[1] ? {{DATA_W{1'b0}}, abs_val(data1_i)}
                             : {{DATA_W{1'b0}}, abs_val(data2_i)};
            state <= ST_BUSY;
          end
        end
        // Iterate: one bit per cycle; the last step feeds the sign fix-up.
        ST_BUSY: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER_CNT - 1)) begin
              result_o <= fix_result(op_q, acc_nxt, neg_a, neg_b, mag_b == '0);
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        // Complete: single-cycle pulse; start_i and flush_i still belong to
        // the finishing instruction and are ignored.
        ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  muldiv_unit dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: signed RISC-style mul/div semantics.
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int     sa;
    int     sb;
    longint p;
    logic [63:0] pv;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    pv = p;
    case (op)
      2'b00: return pv[31:0];
      2'b01: return pv[63:32];
      2'b10: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  // Timing model: m_cyc is the cycle number since acceptance (0 = idle).
  int          m_cyc = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_cyc  = 0;
      m_last = '0;
    end else if (m_cyc == 0) begin
      if (start_i && !flush_i) begin
        m_cyc  = 1;
        m_pend = ref_op(op_i, data1_i, data2_i);
      end
    end else if (m_cyc <= 32) begin
      if (flush_i) m_cyc = 0;
      else begin
        m_cyc++;
        if (m_cyc == 33) m_last = m_pend;
      end
    end else begin
      m_cyc = 0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall", {31'd0, stall_o},
            {31'd0, rst_n_i && ((m_cyc == 0 && start_i && !flush_i) || (m_cyc >= 1 && m_cyc <= 32))});
      check("done", {31'd0, done_o}, {31'd0, m_cyc == 33});
      check("result", result_o, m_last);
    end
  end

  // Launch at posedge+#1 (cycle 0), scramble inputs afterwards, then wait
  // for done_o with a bounded loop. Returns at posedge+#1 in IDLE.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit start_in_done);
    int n;
    n = 0;
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; op_i = ~op; data1_i = $urandom; data2_i = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        n = k;
        break;
      end
    end
    check({name, "_latency"}, n, 33);
    check({name, "_value"}, result_o, exp);
    if (start_in_done) begin
      start_i = 1'b1; flush_i = 1'b1;
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check({name, "_idle_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  initial begin
    int pulses;

    // Pin the reference model with hand-computed values.
    check("pin_mul", ref_op(2'b00, 32'd7, 32'd6), 32'd42);
    check("pin_div", ref_op(2'b10, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("pin_rem", ref_op(2'b11, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("pin_mulh", ref_op(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);

    // Reset state, with start_i asserted while in reset.
    start_i = 1'b1;
    #2;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    start_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'd42,        1'b1);
    run_op("mulh_m1x1",    2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  1'b0);
    run_op("mul_wrap",     2'b00, 32'h00010000, 32'h00010000, 32'd0,         1'b0);
    run_op("mulh_wrap",    2'b01, 32'h00010000, 32'h00010000, 32'd1,         1'b0);
    run_op("mulh_m3x5",    2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF,  1'b0);
    run_op("mul_m3x5",     2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  1'b0);
    run_op("mulh_min2",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000,  1'b0);
    run_op("div_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  1'b0);
    run_op("rem_m7_2",     2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  1'b1);
    run_op("div_100_m7",   2'b10, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2,  1'b0);
    run_op("div_5_0",      2'b10, 32'd5,        32'd0,        32'hFFFFFFFF,  1'b0);
    run_op("rem_5_0",      2'b11, 32'd5,        32'd0,        32'd5,         1'b0);
    run_op("div_m5_0",     2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF,  1'b0);
    run_op("rem_m5_0",     2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB,  1'b0);
    run_op("div_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b0);
    run_op("rem_ovf",      2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,         1'b0);

    // Flush at cycle 10.
    start_i = 1'b1; op_i = 2'b00; data1_i = 32'd9; data2_i = 32'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    check("flush_no_done", pulses, 0);
    check("flush_result_held", result_o, 32'd0);
    @(posedge clk_i); #1;
    run_op("after_flush",  2'b00, 32'd12,       32'd11,       32'd132,       1'b0);

    // Asynchronous reset at cycle 15 of a divide.
    start_i = 1'b1; op_i = 2'b10; data1_i = 32'd1000; data2_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rst_n_i = 1'b1;
    run_op("div_100_7",    2'b10, 32'd100,      32'd7,        32'd14,        1'b0);
    run_op("rem_100_7",    2'b11, 32'd100,      32'd7,        32'd2,         1'b0);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
